// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer driving an external ALU (shift-add / restoring divide).
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are all zero.
module alu_muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o,
  output logic [3:0]      alu_func_o,
  output logic [XLEN-1:0] alu_op1_o,
  output logic [XLEN-1:0] alu_op2_o,
  input  logic [XLEN-1:0] alu_d_i,
  input  logic            alu_ltu_i
);
  localparam logic [3:0] ALU_ADD      = 4'b0000;
  localparam logic [3:0] ALU_SUB      = 4'b1000;
  localparam logic [3:0] ALU_COPY_RS1 = 4'b1111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_e;

  state_e      state_r, state_nxt_s;
  logic [2:0]  op_r;
  logic        neg_r;
  logic [5:0]  cnt_r;
  logic [31:0] hi_r, lo_r, b_r, rsp_data_r;
  logic        sa_s, sb_s, neg_s, special_s, carry_s, sub_s, last_step_s;
  logic [31:0] abs1_s, abs2_s, special_data_s, rem_sh_s, fix_data_s;
  logic [63:0] prod_s;
`ifdef MULDIV_EARLY_OUT_EN
  logic [31:0] mrem_r;
`endif

  // Request decode: operand magnitudes, result sign and the ops that finish without iterating
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (req_op_i)
      3'd1, 3'd4, 3'd6: begin sa_s = req_rs1_i[31]; sb_s = req_rs2_i[31]; end
      3'd2:             begin sa_s = req_rs1_i[31]; sb_s = 1'b0; end
      default:          begin sa_s = 1'b0; sb_s = 1'b0; end
    endcase
    abs1_s = sa_s ? (32'd0 - req_rs1_i) : req_rs1_i;
    abs2_s = sb_s ? (32'd0 - req_rs2_i) : req_rs2_i;
    // remainders follow the dividend sign, everything else the product/quotient sign
    neg_s = (req_op_i[2] && req_op_i[1]) ? sa_s : (sa_s ^ sb_s);
    special_s = 1'b0;
    special_data_s = 32'd0;
    if (req_op_i[2] && (req_rs2_i == 32'd0)) begin
      special_s = 1'b1;
      special_data_s = req_op_i[1] ? req_rs1_i : 32'hFFFF_FFFF;
    end else if (req_op_i[2] && !req_op_i[0] && (req_rs1_i == 32'h8000_0000) && (req_rs2_i == 32'hFFFF_FFFF)) begin
      special_s = 1'b1;
      special_data_s = req_op_i[1] ? 32'd0 : 32'h8000_0000;
    end else if (ZERO_FAST && !req_op_i[2] && ((req_rs1_i == 32'd0) || (req_rs2_i == 32'd0))) begin
      special_s = 1'b1;
      special_data_s = 32'd0;
    end else begin
      special_s = 1'b0;
      special_data_s = 32'd0;
    end
  end

  // Per-step helpers for the current CALC iteration
  always_comb begin
    rem_sh_s = {hi_r[30:0], lo_r[31]};
    carry_s  = lo_r[0] & (alu_d_i < hi_r);
    sub_s    = hi_r[31] | ~alu_ltu_i;
`ifdef MULDIV_EARLY_OUT_EN
    last_step_s = (cnt_r == 6'd31) || (!op_r[2] && ((mrem_r >> 1) == 32'd0));
`else
    last_step_s = (cnt_r == 6'd31);
`endif
  end

  // Result selection and sign fix-up
  always_comb begin
    prod_s = {hi_r, lo_r};
`ifdef MULDIV_EARLY_OUT_EN
    // skipped steps would only have shifted the product right
    if (!op_r[2]) begin
      prod_s = {hi_r, lo_r} >> (6'd32 - cnt_r);
    end else begin
      prod_s = {hi_r, lo_r};
    end
`endif
    case (op_r)
      3'd0:             fix_data_s = neg_r ? (32'd0 - prod_s[31:0]) : prod_s[31:0];
      3'd1, 3'd2, 3'd3: fix_data_s = neg_r ? (~prod_s[63:32] + {31'd0, (prod_s[31:0] == 32'd0)}) : prod_s[63:32];
      3'd4, 3'd5:       fix_data_s = neg_r ? (32'd0 - lo_r) : lo_r;
      default:          fix_data_s = neg_r ? (32'd0 - hi_r) : hi_r;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides everything including a new request
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_nxt_s = req_valid_i ? (special_s ? S_DONE : S_CALC) : S_IDLE;
        S_CALC:  state_nxt_s = last_step_s ? S_FIXUP : S_CALC;
        S_FIXUP: state_nxt_s = S_DONE;
        S_DONE:  state_nxt_s = rsp_ready_i ? S_IDLE : S_DONE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Output decode; the ALU sees idle values outside CALC
  always_comb begin
    req_ready_o = (state_r == S_IDLE);
    busy_o      = (state_r != S_IDLE);
    rsp_valid_o = (state_r == S_DONE);
    rsp_data_o  = rsp_data_r;
    alu_func_o  = ALU_ADD;
    alu_op1_o   = 32'd0;
    alu_op2_o   = 32'd0;
    if (state_r == S_CALC) begin
      if (op_r[2]) begin
        alu_func_o = ALU_SUB;
        alu_op1_o  = rem_sh_s;
      end else begin
        alu_func_o = lo_r[0] ? ALU_ADD : ALU_COPY_RS1;
        alu_op1_o  = hi_r;
      end
      alu_op2_o = b_r;
    end else begin
      alu_func_o = ALU_ADD;
      alu_op1_o  = 32'd0;
      alu_op2_o  = 32'd0;
    end
  end

  // Datapath: operand latch, one shift-add / restoring-divide step per CALC cycle, result capture
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      op_r       <= 3'd0;
      neg_r      <= 1'b0;
      cnt_r      <= 6'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      b_r        <= 32'd0;
      rsp_data_r <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid_i && !flush_i) begin
            op_r       <= req_op_i;
            neg_r      <= neg_s;
            cnt_r      <= 6'd0;
            hi_r       <= 32'd0;
            lo_r       <= req_op_i[2] ? abs1_s : abs2_s;
            b_r        <= req_op_i[2] ? abs2_s : abs1_s;
            rsp_data_r <= special_data_s;
          end
        end
        S_CALC: begin
          cnt_r <= cnt_r + 6'd1;
          if (op_r[2]) begin
            hi_r <= sub_s ? alu_d_i : rem_sh_s;
            lo_r <= {lo_r[30:0], sub_s};
          end else begin
            hi_r <= {carry_s, alu_d_i[31:1]};
            lo_r <= {alu_d_i[0], lo_r[31:1]};
          end
        end
        S_FIXUP: rsp_data_r <= fix_data_s;
        default: rsp_data_r <= rsp_data_r;
      endcase
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Unconsumed multiplier bits, used only to detect the early exit
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      mrem_r <= 32'd0;
    end else if (state_r == S_IDLE && req_valid_i && !flush_i) begin
      mrem_r <= abs2_s;
    end else if (state_r == S_CALC) begin
      mrem_r <= mrem_r >> 1;
    end else begin
      mrem_r <= mrem_r;
    end
  end
`endif

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq; a behavioural ALU closes the loop on the alu_* ports.
module tb_alu_muldiv_seq;
  localparam logic [3:0] ALU_ADD      = 4'b0000;
  localparam logic [3:0] ALU_SUB      = 4'b1000;
  localparam logic [3:0] ALU_COPY_RS1 = 4'b1111;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        busy;
  logic [3:0]  alu_func;
  logic [31:0] alu_op1, alu_op2, alu_d;
  logic        alu_ltu;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk_i(clk), .resetn_i(resetn), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy), .alu_func_o(alu_func), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
    .alu_d_i(alu_d), .alu_ltu_i(alu_ltu)
  );

  always_comb begin
    case (alu_func)
      ALU_ADD:      alu_d = alu_op1 + alu_op2;
      ALU_SUB:      alu_d = alu_op1 - alu_op2;
      ALU_COPY_RS1: alu_d = alu_op1;
      default:      alu_d = 32'hDEAD_BEEF;
    endcase
    alu_ltu = (alu_op1 < alu_op2);
  end

  // Issue one op, wait (bounded) for the response, consume it. lat = cycle of first rsp_valid.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    data = rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if ({req_ready, rsp_valid, busy} !== 3'b100) $display("FAIL reset_hs act=%b exp=100", {req_ready, rsp_valid, busy}); else pass_cnt++;
    total_cnt++; if (rsp_data !== 32'd0) $display("FAIL reset_data act=%h exp=00000000", rsp_data); else pass_cnt++;
    total_cnt++; if (alu_func !== ALU_ADD) $display("FAIL reset_alu_func act=%h exp=%h", alu_func, ALU_ADD); else pass_cnt++;
    total_cnt++; if ({alu_op1, alu_op2} !== 64'd0) $display("FAIL reset_alu_ops act=%h exp=0", {alu_op1, alu_op2}); else pass_cnt++;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({req_ready, busy} !== 2'b10) $display("FAIL post_reset_idle act=%b exp=10", {req_ready, busy}); else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] d;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat, d);
    total_cnt++; if (d !== 32'hFFFF_FFEB) $display("FAIL mul_7x-3 act=%h exp=ffffffeb", d); else pass_cnt++;
    total_cnt++; if (lat !== 34) $display("FAIL mul_latency act=%0d exp=34", lat); else pass_cnt++;
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, d);
    total_cnt++; if (d !== 32'hFFFF_FFFE) $display("FAIL mulhu_max act=%h exp=fffffffe", d); else pass_cnt++;
    total_cnt++; if (lat !== 34) $display("FAIL mulhu_latency act=%0d exp=34", lat); else pass_cnt++;
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, lat, d);
    total_cnt++; if (d !== 32'h4000_0000) $display("FAIL mulh_min act=%h exp=40000000", d); else pass_cnt++;
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, lat, d);
    total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL mulhsu_-1x2 act=%h exp=ffffffff", d); else pass_cnt++;
    do_op(3'd0, 32'd0, 32'd5, lat, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL mul_zero act=%h exp=00000000", d); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL mul_zero_latency act=%0d exp=1", lat); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat; logic [31:0] d;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, d);
    total_cnt++; if (d !== 32'hFFFF_FFFD) $display("FAIL div_-7/2 act=%h exp=fffffffd", d); else pass_cnt++;
    total_cnt++; if (lat !== 34) $display("FAIL div_latency act=%0d exp=34", lat); else pass_cnt++;
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, lat, d);
    total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL rem_-7/2 act=%h exp=ffffffff", d); else pass_cnt++;
    do_op(3'd5, 32'd100, 32'd7, lat, d);
    total_cnt++; if (d !== 32'd14) $display("FAIL divu_100/7 act=%h exp=0000000e", d); else pass_cnt++;
    do_op(3'd7, 32'd100, 32'd7, lat, d);
    total_cnt++; if (d !== 32'd2) $display("FAIL remu_100/7 act=%h exp=00000002", d); else pass_cnt++;
    do_op(3'd4, 32'd5, 32'd0, lat, d);
    total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL div_by_zero act=%h exp=ffffffff", d); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL div_by_zero_latency act=%0d exp=1", lat); else pass_cnt++;
    do_op(3'd7, 32'd9, 32'd0, lat, d);
    total_cnt++; if (d !== 32'd9) $display("FAIL remu_by_zero act=%h exp=00000009", d); else pass_cnt++;
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL rem_overflow act=%h exp=00000000", d); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL rem_overflow_latency act=%0d exp=1", lat); else pass_cnt++;
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, d);
    total_cnt++; if (d !== 32'h8000_0000) $display("FAIL div_overflow act=%h exp=80000000", d); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; logic stable;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd100; req_rs2 = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat !== 34) $display("FAIL hold_latency act=%0d exp=34", lat); else pass_cnt++;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_data !== 32'd14 || req_ready !== 1'b0 || rsp_valid !== 1'b1) stable = 1'b0;
    end
    total_cnt++; if (stable !== 1'b1) $display("FAIL hold_stable act=%b exp=1 data=%h", stable, rsp_data); else pass_cnt++;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd7; req_rs1 = 32'd100; req_rs2 = 32'd7;
    @(posedge clk); #1;
    total_cnt++; if ({req_ready, busy, rsp_valid} !== 3'b100) $display("FAIL consume_to_idle act=%b exp=100", {req_ready, busy, rsp_valid}); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept act=%b exp=1", busy); else pass_cnt++;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat !== 34 || rsp_data !== 32'd2) $display("FAIL b2b_result act=%0d/%h exp=34/00000002", lat, rsp_data); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush_reset();
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_rs1 = 32'd7; req_rs2 = 32'h8000_0003;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++; if ({busy, req_ready} !== 2'b10) $display("FAIL calc_busy act=%b exp=10", {busy, req_ready}); else pass_cnt++;
    total_cnt++; if (alu_func !== ALU_COPY_RS1 || alu_op2 !== 32'd7) $display("FAIL calc_alu_drive act=%h/%h exp=%h/00000007", alu_func, alu_op2, ALU_COPY_RS1); else pass_cnt++;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total_cnt++; if ({busy, rsp_valid, req_ready} !== 3'b001) $display("FAIL flush_idle act=%b exp=001", {busy, rsp_valid, req_ready}); else pass_cnt++;
    total_cnt++; if (alu_func !== ALU_ADD || {alu_op1, alu_op2} !== 64'd0) $display("FAIL flush_alu_idle act=%h/%h", alu_func, {alu_op1, alu_op2}); else pass_cnt++;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd100; req_rs2 = 32'd7;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL flush_beats_accept act=%b exp=0", busy); else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd100; req_rs2 = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    total_cnt++; if ({busy, rsp_valid, req_ready} !== 3'b001) $display("FAIL async_reset_idle act=%b exp=001", {busy, rsp_valid, req_ready}); else pass_cnt++;
    total_cnt++; if (alu_func !== ALU_ADD || {alu_op1, alu_op2} !== 64'd0 || rsp_data !== 32'd0) $display("FAIL async_reset_outs act=%h/%h/%h", alu_func, {alu_op1, alu_op2}, rsp_data); else pass_cnt++;
    @(negedge clk); resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL no_rsp_after_abort act=%b exp=0", seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
